// File: rtl/mant_mult_seq_pkg.sv
// Shared FMAC datapath definitions: multiplier FSM states and mantissa widths.
package fmac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MANT_W = 8;
    localparam int PROD_W = 2 * MANT_W;

endpackage

// File: rtl/mant_mult_seq_if.sv
// Operand and product valid/ready handshakes of the mantissa multiplier.
interface mant_mult_seq_if
    import fmac_pkg::*;
#(
    parameter int W = MANT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;

    // Producer of operands and consumer of the product
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    // The multiplier itself
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/mant_mult_seq_add.sv
// N-bit ripple-carry adder made of chained 1-bit full adders.
module mult_add_w1 #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];
endmodule

// File: rtl/mant_mult_seq.sv
// Iterative shift-and-add unsigned mantissa multiplier: W add/shift cycles
// through one (W+1)-bit ripple adder, product held until downstream takes it.
module mant_mult_seq
    import fmac_pkg::*;
#(
    parameter int W = MANT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    mant_mult_seq_if.slave bus
);
    localparam int                CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W - 1);

    state_t            state;
    state_t            next_state;
    logic [W-1:0]      mcand;
    logic [W-1:0]      acc_hi;
    logic [W-1:0]      acc_lo;
    logic [CNT_W-1:0]  cnt;
    logic [2*W-1:0]    result;

    logic [W:0]        add_a;
    logic [W:0]        add_b;
    logic [W:0]        sum;
    logic              add_cout;

    logic              in_ready;
    logic              out_valid;
    logic              accept;
    logic              last_step;

    assign accept    = bus.in_valid && in_ready;
    assign last_step = (cnt == CNT_LAST);

    // Partial-product step: add the multiplicand when the current multiplier bit is set
    always_comb begin
        add_a = {1'b0, acc_hi};
        add_b = acc_lo[0] ? {1'b0, mcand} : '0;
    end

    mult_add_w1 #(
        .N (W + 1)
    ) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .s    (sum),
        .cout (add_cout)
    );

    // Two W-bit values plus one leading zero each can never carry out of W+1 bits
    carry_never_set: assert property (@(posedge clk) disable iff (!rst_n) !add_cout);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state: IDLE -> RUN on accept, RUN for W steps, DONE until consumed
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (bus.in_valid) next_state = RUN;
            RUN:  if (last_step)    next_state = DONE;
            DONE: if (bus.out_ready) next_state = bus.in_valid ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready lets a new pair in as the product leaves
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready = 1'b1;
            RUN:     in_ready = 1'b0;
            DONE: begin
                in_ready  = bus.out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Operand load on accept, one add/shift per RUN cycle, result captured on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            mcand  <= bus.a;
            acc_hi <= '0;
            acc_lo <= bus.b;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc_hi <= sum[W:1];
            acc_lo <= {sum[0], acc_lo[W-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (last_step) result <= {sum[W:1], sum[0], acc_lo[W-1:1]};
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.product   = result;
endmodule

// File: tb/tb_mant_mult_seq.sv
// Self-checking bench for mant_mult_seq: directed cases plus a randomized
// stream scored against a plain a*b reference queue.
module tb_mant_mult_seq;
    import fmac_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    mant_mult_seq_if #(.W(MANT_W)) bus ();

    mant_mult_seq #(.W(MANT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    function automatic logic [PROD_W-1:0] ref_mul(input logic [MANT_W-1:0] x, input logic [MANT_W-1:0] y);
        return {8'd0, x} * {8'd0, y};
    endfunction

    task automatic run_one(input logic [7:0] x, input logic [7:0] y);
        int lat;
        bus.a = x;
        bus.b = y;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("one_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        wait_done(lat);
        chk("one_latency", lat, 8);
        chk("one_product", bus.product, ref_mul(x, y));
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("one_back_idle_valid", bus.out_valid, 0);
        chk("one_back_idle_ready", bus.in_ready, 1);
    endtask

    initial begin
        int lat;
        int t_prev;
        int seen;
        int accepted;
        int popped;
        int extra;
        int guard;
        logic [7:0]        ea [4];
        logic [7:0]        eb [4];
        logic [PROD_W-1:0] exp_q [$];
        logic [PROD_W-1:0] e;

        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_product", bus.product, 0);
        rst_n = 1'b1;
        tick();

        // Directed single products, including all-ones and zero multiplicand
        run_one(8'd13, 8'd11);
        run_one(8'hFF, 8'hFF);
        run_one(8'h00, 8'hA5);
        run_one(8'h80, 8'h01);

        // Stall in DONE with a new pair waiting
        bus.a = 8'd7;
        bus.b = 8'd9;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk("stall_accept_ready", bus.in_ready, 1);
        tick();
        wait_done(lat);
        chk("stall_latency", lat, 8);
        chk("stall_product", bus.product, 63);
        for (int i = 0; i < 5; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            #1;
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_hold", bus.product, 63);
            tick();
        end
        chk("stall_hold_end", bus.product, 63);
        bus.a = 8'd200;
        bus.b = 8'd3;
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", bus.in_ready, 1);
        tick();
        chk("release_consumed", bus.out_valid, 0);
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom);
        wait_done(lat);
        chk("release_latency", lat, 8);
        chk("release_product", bus.product, 600);
        tick();
        chk("release_idle", bus.out_valid, 0);

        // Back-to-back stream of four pairs with out_ready held high
        for (int i = 0; i < 4; i++) begin
            ea[i] = 8'($urandom_range(1, 255));
            eb[i] = 8'($urandom_range(1, 255));
        end
        bus.out_ready = 1'b1;
        bus.a = ea[0];
        bus.b = eb[0];
        bus.in_valid = 1'b1;
        tick();
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                bus.a = ea[i+1];
                bus.b = eb[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            wait_done(lat);
            chk("stream_latency", lat, 8);
            chk("stream_product", bus.product, ref_mul(ea[i], eb[i]));
            if (i > 0) chk("stream_spacing", cyc - t_prev, 9);
            t_prev = cyc;
            tick();
        end
        chk("stream_idle", bus.out_valid, 0);

        // Reset in the middle of RUN
        bus.a = 8'd5;
        bus.b = 8'd5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("prerst_busy", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_product", bus.product, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        chk("postrst_no_stale", seen, 0);
        run_one(8'd3, 8'd4);

        // Randomized pairs with random stalls against the reference queue
        accepted = 0;
        popped = 0;
        extra = 0;
        guard = 0;
        while ((accepted < 1000 || exp_q.size() != 0) && guard < 60000) begin
            if (accepted < 1000) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    chk("rand_product", bus.product, e);
                end
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                exp_q.push_back(ref_mul(bus.a, bus.b));
                accepted++;
            end
            tick();
            guard++;
        end
        chk("rand_accepted", accepted, 1000);
        chk("rand_popped", popped, 1000);
        chk("rand_no_extra", extra, 0);
        chk("rand_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mant_mult_seq.md
# mant_mult_seq

Iterative shift-and-add unsigned mantissa multiplier for the FMAC datapath. Accepts two W-bit operands over a valid/ready handshake, computes the 2W-bit product in W add/shift cycles through a single (W+1)-bit ripple adder, and presents the result on a second valid/ready handshake. Sits directly upstream of the accumulate adder, which consumes its product.

## Interface
- W, default 8: operand width; product is 2W bits, internal adder is W+1 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands this cycle.
- a  in  W  multiplicand, unsigned.
- b  in  W  multiplier, unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  2W  a*b, unsigned.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: mcand<=a, acc_hi<=0, acc_lo<=b, cnt<=0, go RUN.
- RUN (exactly W cycles, cnt 0..W-1), per cycle:
  - sum[W:0] = {0,acc_hi} + (acc_lo[0] ? {0,mcand} : 0), via the adder sub-module, carry-in 0.
  - acc_hi<=sum[W:1]; acc_lo<={sum[0], acc_lo[W-1:1]}; cnt<=cnt+1.
  - At cnt==W-1: result<={sum[W:1], sum[0], acc_lo[W-1:1]}, go DONE.
- DONE: out_valid=1, product=result, held stable until out_ready.
  - out_ready=1: product consumed. If in_valid also 1, new operands accepted same edge (in_ready = IDLE || (DONE && out_ready)), go RUN; else go IDLE.
  - out_ready=0: stay DONE; in_ready=0, in_valid ignored.
- Width: sum never exceeds W+1 bits; (2^W-1)^2 fits 2W bits; no overflow or saturation.
- Fixed latency regardless of operand values (zero operands still take W cycles).
- a/b sampled only on accept edge; changes at other times ignored.

## Timing
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, product=0, cnt=0, internal regs 0. In-flight operation discarded, no partial output. Release synchronous to clk (first accept possible on first edge with rst_n high).
- Latency: accept at edge E0 -> RUN on E1..E8 (W=8) -> out_valid=1 after E8, i.e. 8 cycles accept-to-valid.
- Throughput: back-to-back with out_ready held high, one product per W+1 cycles.
- in_ready is combinational from state and out_ready only; out_valid and product are registered.
- product changes only on RUN->DONE edge; stable throughout DONE including stall.

## Structure
- Shared package fmac_pkg: state enum (IDLE, RUN, DONE), MANT_W=8, PROD_W=2*MANT_W.
- One sub-module: mult_add_w1, a (W+1)-bit ripple-carry adder built from 1-bit full adders (a, b, cin -> s, cout); instantiated once, carry-in tied 0.
- Counter width $clog2(W); no other sub-modules.

## Test plan
- Reset then a=8'd13, b=8'd11, out_ready=1 -> out_valid 8 cycles after accept, product=16'd143, returns IDLE.
- a=8'hFF, b=8'hFF -> product=16'hFE01; a=0, b=8'hA5 -> product=0, still 8-cycle latency.
- Hold out_ready=0 for 5 cycles after DONE with in_valid=1 and new a/b -> product stable at prior value, in_ready=0, new operands not taken; raise out_ready -> consumed and new pair accepted same edge.
- Stream 4 pairs with out_ready=1 continuously -> products correct in order, 9-cycle spacing.
- Assert rst_n=0 at RUN cycle 4 -> immediately out_valid=0, product=0, in_ready=1; no stale result after release.
- Random 1000 pairs with random out_ready stalls -> each product equals a*b against reference model, no drops or duplicates.
